counter_arb_ctrl: RTL and testbench
===================================

Name: counter_arb_ctrl

Overview:
Controller and round-robin arbiter that shares one counter_8bit instance between NREQ requesters. Each requester asks for a count-to-target run. The block grants one requester at a time, clears the counter, enables it until its output equals the latched target, then pulses done to the owner. It sits between the requester logic and the counter's clear/enable inputs and observes the counter output.

Parameters:
NREQ, 2, number of requesters (2..8)
WIDTH, 8, counter/target width; must match the counter datapath

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request, level; held until done/err
tgt  input  NREQ*WIDTH  per-requester target; slice i = tgt[i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered; high from CLEAR through DONE
done  output  NREQ  one-cycle completion pulse to the owner
err  output  NREQ  one-cycle timeout pulse to the owner; constant 0 when the feature is absent
busy  output  1  high whenever state != IDLE
cnt_clr  output  1  synchronous clear to the counter
cnt_en  output  1  count enable to the counter
cnt_out  input  WIDTH  counter output value

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, owner=0, tgt_q=0, gnt=0, done=0, err=0, busy=0, cnt_clr=0, cnt_en=0. Reset mid-run abandons the run with no done. The counter is reset separately on its own rst.
- FSM states are IDLE, CLEAR, COUNT, DONE.
- IDLE: if any req bit is set, pick the first set bit at or after rr_ptr (wrapping), latch owner and tgt_q = owner's tgt slice, go to CLEAR. Otherwise stay.
- CLEAR: cnt_clr=1 for exactly one cycle, gnt[owner]=1, go to COUNT.
- COUNT: cnt_en = (cnt_out != tgt_q), combinational from state, tgt_q and cnt_out.
  - cnt_out == tgt_q: go to DONE; no increment that cycle.
  - req[owner] drops: abort to IDLE, no done, rr_ptr = owner+1.
- DONE: done[owner]=1 for one cycle, rr_ptr = (owner+1) mod NREQ, gnt cleared on exit, go to IDLE.
- Latency: req sampled in IDLE at cycle t gives CLEAR at t+1, COUNT from t+2, done pulse at t+T+3 for target T.
  - T=0: done at t+3 with zero enabled cycles.
  - T=2^WIDTH-1: 255 enabled cycles.
- tgt is sampled only at grant; later changes are ignored.
- Simultaneous requests are resolved by rr_ptr. The previous owner is lowest priority next time, so there is no starvation.
- A req still high during the owner's DONE cycle is re-evaluated in IDLE the next cycle; another pending requester wins.
- A new request is never granted from the DONE cycle; the minimum gap between grants is one IDLE cycle.
- At most one gnt bit is high at any time; cnt_en and cnt_clr are never high together.

Optional Feature:
COUNTER_ARB_TIMEOUT_EN
- Present: a WIDTH+1-bit watchdog counts cycles in COUNT. If it reaches 2^WIDTH+1 without a match (counter stuck or mis-wired), pulse err[owner] for one cycle, drop cnt_en, go to IDLE without done, rr_ptr = owner+1. The watchdog clears on entry to CLEAR.
- Absent: no watchdog logic; err is tied to 0; COUNT waits indefinitely.

Decomposition:
- Package counter_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_e {IDLE, CLEAR, COUNT, DONE};
  - default constants NREQ_DEF=2, WIDTH_DEF=8;
  - function rr_pick(req, ptr) returning the one-hot winner.
- Sub-module rr_arbiter(NREQ): combinational winner from req and rr_ptr, plus a valid flag. The FSM and pointer register stay in counter_arb_ctrl.

Test Plan:
- Reset asserted mid-COUNT (T=50, 10 cycles in) -> gnt, cnt_en and busy go to 0 immediately (async); no done; next request is arbitrated from rr_ptr=0.
- Single request, req[0]=1 with tgt[0]=5 sampled at cycle t -> cnt_clr high at t+1, cnt_en high for exactly 5 cycles, done[0] pulses at t+8, gnt[0] falls after t+8.
- Contention, req=2'b11 with tgt=3 and tgt=7 after reset -> requester 0 served first (done at +6); requester 1 granted on the following IDLE cycle, done 10 cycles after its grant evaluation.
- Fairness, both requests held permanently -> grants alternate 0,1,0,1 over 4 runs, never the same owner twice in a row.
- Edge targets, tgt=0 -> zero enable cycles and done at +3. tgt=255 -> 255 enable cycles and cnt_out=255 when done fires.
- Abort, req[1] dropped 4 cycles into COUNT -> cnt_en falls the same cycle, no done[1], busy low next cycle. With COUNTER_ARB_TIMEOUT_EN and cnt_out stuck at 0 with tgt=9 -> err pulses after 257 COUNT cycles.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// counter_arb_pkg: shared FSM state type, default sizes and the
// round-robin pick helper used by the counter arbiter.
package counter_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   localparam int NREQ_DEF  = 2;
   localparam int WIDTH_DEF = 8;
   localparam int NREQ_MAX  = 8;

   // First set request at or after ptr, wrapping inside nreq; one-hot result.
   function automatic logic [NREQ_MAX-1:0] rr_pick(
      input logic [NREQ_MAX-1:0] req,
      input logic [2:0]          ptr,
      input int                  nreq
   );
      logic [NREQ_MAX-1:0] win;
      logic                found;
      int                  idx;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ_MAX; k++) begin
         idx = (int'(ptr) + k) % nreq;
         if ((k < nreq) && !found && req[idx[2:0]]) begin
            win[idx[2:0]] = 1'b1;
            found         = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/counter_arb_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner selection. Produces the
// one-hot winner, its binary index and a valid flag; holds no state.
module rr_arbiter
   import counter_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [PW-1:0]   win_idx,
   output logic            valid
);

   logic [NREQ_MAX-1:0] req_ext_s;
   logic [2:0]          ptr_ext_s;
   logic [NREQ_MAX-1:0] pick_s;

   // Widen to the helper's fixed width, pick, and encode the winner index.
   always_comb begin
      req_ext_s           = '0;
      req_ext_s[NREQ-1:0] = req;
      ptr_ext_s           = 3'd0;
      ptr_ext_s[PW-1:0]   = ptr;
      pick_s              = rr_pick(req_ext_s, ptr_ext_s, NREQ);
      win                 = pick_s[NREQ-1:0];
      valid               = |pick_s;
      win_idx             = '0;
      for (int i = 0; i < NREQ; i++) begin
         win_idx = win_idx | (pick_s[i] ? PW'(i) : {PW{1'b0}});
      end
   end

endmodule

// File: rtl/counter_arb_ctrl.sv
// counter_arb_ctrl: shares one external counter between NREQ requesters.
// Grants round-robin, clears the counter, enables it until it reaches the
// latched target, then pulses done to the owner.
// Optional build macro COUNTER_ARB_TIMEOUT_EN adds a COUNT watchdog that
// pulses err and abandons the run when the counter never matches.
module counter_arb_ctrl
   import counter_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] tgt,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic [NREQ-1:0]       err,
   output logic                  busy,
   output logic                  cnt_clr,
   output logic                  cnt_en,
   input  logic [WIDTH-1:0]      cnt_out
);

   localparam int            PW       = $clog2(NREQ);
   localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

   arb_state_e       state_r;
   logic [PW-1:0]    rr_ptr_r;
   logic [PW-1:0]    owner_r;
   logic [WIDTH-1:0] tgt_q_r;
   logic [NREQ-1:0]  gnt_r;
   logic [NREQ-1:0]  done_r;
   logic [NREQ-1:0]  err_r;
   logic             busy_r;
   logic             cnt_clr_r;

   logic [NREQ-1:0]  win_s;
   logic [PW-1:0]    win_idx_s;
   logic             win_valid_s;
   logic [WIDTH-1:0] win_tgt_s;
   logic [PW-1:0]    next_ptr_s;
   logic [NREQ-1:0]  owner_oh_s;
   logic             owner_req_s;
   logic             match_s;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_arbiter (
      .req     (req),
      .ptr     (rr_ptr_r),
      .win     (win_s),
      .win_idx (win_idx_s),
      .valid   (win_valid_s)
   );

   // Owner-derived helpers: target of the winner, next pointer, match flag.
   always_comb begin
      win_tgt_s   = tgt[int'(win_idx_s)*WIDTH +: WIDTH];
      next_ptr_s  = (owner_r == LAST_IDX) ? {PW{1'b0}} : owner_r + PW'(1);
      owner_oh_s  = NREQ'(1) << owner_r;
      owner_req_s = req[owner_r];
      match_s     = (cnt_out == tgt_q_r);
   end

   // Enable stops in the same cycle as a match or an owner withdrawal.
   assign cnt_en  = (state_r == COUNT) && owner_req_s && !match_s;
   assign cnt_clr = cnt_clr_r;
   assign gnt     = gnt_r;
   assign done    = done_r;
   assign err     = err_r;
   assign busy    = busy_r;

`ifdef COUNTER_ARB_TIMEOUT_EN
   localparam logic [WIDTH:0] WD_LIMIT = {1'b1, {WIDTH{1'b0}}};
   logic [WIDTH:0] wd_r;
   logic           timeout_s;

   assign timeout_s = (wd_r == WD_LIMIT);

   // Watchdog: counts COUNT cycles, restarted for every run in CLEAR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_r <= '0;
      end else if (state_r == CLEAR) begin
         wd_r <= '0;
      end else if ((state_r == COUNT) && !timeout_s) begin
         wd_r <= wd_r + {{WIDTH{1'b0}}, 1'b1};
      end else begin
         wd_r <= wd_r;
      end
   end
`endif

   // Arbitration FSM with registered grant, pulse and clear outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         rr_ptr_r  <= '0;
         owner_r   <= '0;
         tgt_q_r   <= '0;
         gnt_r     <= '0;
         done_r    <= '0;
         err_r     <= '0;
         busy_r    <= 1'b0;
         cnt_clr_r <= 1'b0;
      end else begin
         done_r    <= '0;
         err_r     <= '0;
         cnt_clr_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (win_valid_s) begin
                  owner_r   <= win_idx_s;
                  tgt_q_r   <= win_tgt_s;
                  gnt_r     <= win_s;
                  busy_r    <= 1'b1;
                  cnt_clr_r <= 1'b1;
                  state_r   <= CLEAR;
               end else begin
                  gnt_r     <= '0;
                  busy_r    <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            CLEAR: begin
               state_r <= COUNT;
            end
            COUNT: begin
               if (match_s) begin
                  done_r  <= owner_oh_s;
                  state_r <= DONE;
               end else if (!owner_req_s) begin
                  rr_ptr_r <= next_ptr_s;
                  gnt_r    <= '0;
                  busy_r   <= 1'b0;
                  state_r  <= IDLE;
`ifdef COUNTER_ARB_TIMEOUT_EN
               end else if (timeout_s) begin
                  err_r    <= owner_oh_s;
                  rr_ptr_r <= next_ptr_s;
                  gnt_r    <= '0;
                  busy_r   <= 1'b0;
                  state_r  <= IDLE;
`endif
               end else begin
                  state_r <= COUNT;
               end
            end
            DONE: begin
               rr_ptr_r <= next_ptr_s;
               gnt_r    <= '0;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               gnt_r   <= '0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_arb_ctrl.sv
// tb_counter_arb_ctrl: directed bench for counter_arb_ctrl with a local
// counter, a timeline-based reference model checked every cycle, and
// hand-computed cycle/enable expectations for each scenario.
module tb_counter_arb_ctrl;

   localparam int NREQ  = 2;
   localparam int WIDTH = 8;
`ifdef COUNTER_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] tgt;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic [NREQ-1:0]       err;
   logic                  busy;
   logic                  cnt_clr;
   logic                  cnt_en;
   logic [WIDTH-1:0]      cnt_out;
   logic                  stuck;

   int cyc        = 0;
   int total      = 0;
   int bad        = 0;
   int en_total   = 0;
   int done_total = 0;

   // reference model: where the current run is on its timeline
   bit m_act, m_done;
   int m_own, m_tgt, m_age, m_ptr, m_err;

   counter_arb_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .tgt     (tgt),
      .gnt     (gnt),
      .done    (done),
      .err     (err),
      .busy    (busy),
      .cnt_clr (cnt_clr),
      .cnt_en  (cnt_en),
      .cnt_out (cnt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // shared counter; stuck freezes it to emulate a broken datapath
   always @(posedge clk or posedge rst) begin
      if (rst)                    cnt_out <= '0;
      else if (cnt_clr)           cnt_out <= '0;
      else if (cnt_en && !stuck)  cnt_out <= cnt_out + 8'd1;
   end

   // running totals of enabled cycles and done pulses
   always @(negedge clk) begin
      if (cnt_en) en_total   <= en_total + 1;
      if (|done)  done_total <= done_total + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // age 1 = CLEAR cycle, age>=2 = counting (counter value age-2), then done
   task automatic model_step();
      int v, w;
      m_err <= -1;
      if (!m_act) begin
         w = pick(req, m_ptr);
         if (w >= 0) begin
            m_act  <= 1'b1;
            m_own  <= w;
            m_tgt  <= int'(tgt[w*WIDTH +: WIDTH]);
            m_age  <= 1;
            m_done <= 1'b0;
         end
      end else if (m_done) begin
         m_act  <= 1'b0;
         m_done <= 1'b0;
         m_ptr  <= (m_own + 1) % NREQ;
      end else if (m_age == 1) begin
         m_age <= 2;
      end else begin
         v = stuck ? 0 : m_age - 2;
         if (v == m_tgt) begin
            m_done <= 1'b1;
         end else if (!req[m_own]) begin
            m_act <= 1'b0;
            m_ptr <= (m_own + 1) % NREQ;
         end else if (TO_EN && (m_age - 2) == 256) begin
            m_act <= 1'b0;
            m_err <= m_own;
            m_ptr <= (m_own + 1) % NREQ;
         end else begin
            m_age <= m_age + 1;
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act  <= 1'b0;
         m_done <= 1'b0;
         m_own  <= 0;
         m_tgt  <= 0;
         m_age  <= 0;
         m_ptr  <= 0;
         m_err  <= -1;
      end else begin
         model_step();
      end
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin : compare
      logic [NREQ-1:0] eg, ed, ee;
      bit              counting;
      int              v;
      eg       = m_act ? (NREQ'(1) << m_own) : '0;
      ed       = (m_act && m_done) ? (NREQ'(1) << m_own) : '0;
      ee       = (m_err >= 0) ? (NREQ'(1) << m_err) : '0;
      counting = m_act && !m_done && (m_age >= 2);
      v        = stuck ? 0 : m_age - 2;
      chk("gnt", gnt, eg);
      chk("done", done, ed);
      chk("err", err, ee);
      chk("busy", busy, m_act);
      chk("cnt_clr", cnt_clr, m_act && !m_done && (m_age == 1));
      chk("cnt_en", cnt_en, counting && (v != m_tgt) && req[m_own]);
      chk("gnt_onehot0", $onehot0(gnt), 1);
      chk("clr_en_excl", cnt_clr & cnt_en, 0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(input logic [NREQ-1:0] mask, input bit use_err,
                             input int budget, input string name,
                             output int at_cyc, output logic [NREQ-1:0] seen);
      int n;
      n      = 0;
      at_cyc = -1;
      seen   = '0;
      while (n < budget) begin
         step();
         n++;
         seen = (use_err ? err : done) & mask;
         if (seen != '0) begin
            at_cyc = cyc;
            break;
         end
      end
      chk({name, "_within_budget"}, int'(at_cyc >= 0), 1);
   endtask

   initial begin
      int              t, dc, eb, db;
      logic [NREQ-1:0] sn;
      int              seq[$];
      req   = '0;
      tgt   = '0;
      stuck = 1'b0;
      rst   = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_clr", cnt_clr, 0);
      chk("rst_en", cnt_en, 0);
      rst = 1'b0;
      step();

      // single request, target 5
      t = cyc; eb = en_total;
      tgt[0 +: WIDTH] = 8'd5; req = 2'b01;
      step();
      chk("single_clr", cnt_clr, 1);
      chk("single_gnt", gnt, 1);
      wait_pulse(2'b01, 1'b0, 50, "single_done", dc, sn);
      chk("single_done_cyc", dc, t + 8);
      chk("single_en_cycles", en_total - eb, 5);
      chk("single_cnt_at_done", cnt_out, 5);
      req = 2'b00;
      step();
      chk("single_gnt_fall", gnt, 0);

      // reset 10 cycles into COUNT of a target-50 run for requester 1
      t = cyc; db = done_total;
      tgt[WIDTH +: WIDTH] = 8'd50; req = 2'b10;
      repeat (12) step();
      chk("rstmid_busy_before", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_gnt", gnt, 0);
      chk("rstmid_en", cnt_en, 0);
      chk("rstmid_busy", busy, 0);
      req = 2'b00;
      step(); step();
      rst = 1'b0;
      step();
      chk("rstmid_no_done", done_total - db, 0);

      // contention after reset: pointer back at 0, so requester 0 first
      t = cyc;
      tgt[0 +: WIDTH] = 8'd3; tgt[WIDTH +: WIDTH] = 8'd7; req = 2'b11;
      wait_pulse(2'b11, 1'b0, 50, "cont_first", dc, sn);
      chk("cont_first_owner", sn, 2'b01);
      chk("cont_first_cyc", dc, t + 6);
      req[0] = 1'b0;
      wait_pulse(2'b10, 1'b0, 50, "cont_second", dc, sn);
      chk("cont_second_cyc", dc, t + 17);
      req[1] = 1'b0;
      step();

      // fairness with both requests held
      tgt[0 +: WIDTH] = 8'd1; tgt[WIDTH +: WIDTH] = 8'd2; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_pulse(2'b11, 1'b0, 50, "fair_run", dc, sn);
         seq.push_back((sn == 2'b10) ? 1 : 0);
      end
      req = 2'b00;
      for (int k = 0; k < 4; k++) chk($sformatf("fair_owner%0d", k), seq[k], k % 2);
      step();

      // target 0
      t = cyc; eb = en_total;
      tgt[0 +: WIDTH] = 8'd0; req = 2'b01;
      wait_pulse(2'b01, 1'b0, 20, "t0_done", dc, sn);
      chk("t0_done_cyc", dc, t + 3);
      chk("t0_en_cycles", en_total - eb, 0);
      req = 2'b00;
      step();

      // target 255
      t = cyc; eb = en_total;
      tgt[WIDTH +: WIDTH] = 8'd255; req = 2'b10;
      wait_pulse(2'b10, 1'b0, 400, "t255_done", dc, sn);
      chk("t255_done_cyc", dc, t + 258);
      chk("t255_en_cycles", en_total - eb, 255);
      chk("t255_cnt_at_done", cnt_out, 255);
      req = 2'b00;
      step();

      // abort 4 cycles into COUNT
      t = cyc; db = done_total;
      tgt[WIDTH +: WIDTH] = 8'd20; req = 2'b10;
      repeat (6) step();
      chk("abort_en_before", cnt_en, 1);
      req = 2'b00;
      #1;
      chk("abort_en_same_cycle", cnt_en, 0);
      step();
      chk("abort_busy_next", busy, 0);
      chk("abort_gnt_next", gnt, 0);
      chk("abort_no_done", done_total - db, 0);
      step();

      // counter stuck at 0 with target 9
      t = cyc; db = done_total;
      stuck = 1'b1;
      tgt[0 +: WIDTH] = 8'd9; req = 2'b01;
`ifdef COUNTER_ARB_TIMEOUT_EN
      wait_pulse(2'b01, 1'b1, 400, "stuck_err", dc, sn);
      chk("stuck_err_cyc", dc, t + 259);
      chk("stuck_busy_at_err", busy, 0);
      req = 2'b00;
`else
      repeat (300) step();
      chk("stuck_still_busy", busy, 1);
      chk("stuck_still_gnt", gnt, 1);
      chk("stuck_err_zero", err, 0);
      req = 2'b00;
      step();
      chk("stuck_abort_busy", busy, 0);
`endif
      chk("stuck_no_done", done_total - db, 0);
      step();
      stuck = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
